dds_avalon_cfg_master: RTL and testbench
========================================

DDS_AVALON_CFG_MASTER -- requirements
Module: dds_avalon_cfg_master

Interface
REQ-001 Parameter VERIFY, default 1, meaning: 1 = read back and compare all 16 table words after the write pass; 0 = skip the read-back pass.
REQ-002 Parameter RD_LATENCY, default 1, meaning: cycles from an accepted read to valid avm_readdata (range 1-4).
REQ-003 clock  input  1  single clock for all logic.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 i_go  input  1  one-cycle start request.
REQ-006 i_base  input  32  increment value for table entry 0.
REQ-007 i_step  input  32  increment difference between consecutive table entries.
REQ-008 i_enable  input  1  value programmed into control bit 0.
REQ-009 i_tipo_ajuste  input  1  value programmed into control bit 1.
REQ-010 avm_chipselect  output  1  Avalon-MM chip select.
REQ-011 avm_write  output  1  Avalon-MM write strobe.
REQ-012 avm_read  output  1  Avalon-MM read strobe.
REQ-013 avm_address  output  3  Avalon-MM word address.
REQ-014 avm_writedata  output  32  Avalon-MM write data.
REQ-015 avm_readdata  input  32  Avalon-MM read data.
REQ-016 avm_waitrequest  input  1  slave stall; tie to 0 when the slave has no stall.
REQ-017 o_busy  output  1  high from i_go acceptance until o_done.
REQ-018 o_done  output  1  one-cycle pulse when the sequence completes.
REQ-019 o_error  output  1  read-back mismatch flag for the last run.
REQ-020 o_err_index  output  4  index of the first mismatching table entry.

Function
REQ-021 The slave register map SHALL be: 0 = control (bit0 enable, bit1 tipo_ajuste, other bits written as 0), 1 = start (any write pulses start), 2 = table index (bits 3:0), 3 = table data (read/write of table[index]).
REQ-022 Table entry k (k = 0..15) SHALL be i_base + k*i_step mod 2^32, produced by an accumulator; no multiplier is used.
REQ-023 i_base, i_step, i_enable and i_tipo_ajuste SHALL be latched on the cycle i_go is accepted; later input changes have no effect on the run.
REQ-024 i_go SHALL be accepted only in IDLE; i_go while o_busy is high is ignored.
REQ-025 State sequence: IDLE -> W_IDX -> W_DAT, repeated for k = 0..15.
REQ-026 If VERIFY = 1, the write pass SHALL be followed by V_IDX -> V_RD -> V_WAIT, repeated for k = 0..15.
REQ-027 After the table passes, the sequence SHALL continue W_CTRL -> W_START -> DONE -> IDLE.
REQ-028 Each bus transfer SHALL assert avm_chipselect together with exactly one of avm_write/avm_read, and SHALL hold address, writedata and both strobes stable while avm_waitrequest = 1.
REQ-029 A transfer completes on the first rising edge with avm_waitrequest = 0; the FSM advances on that edge.
REQ-030 Between transfers, all strobes SHALL be 0 for at least 0 cycles; back-to-back transfers are allowed.
REQ-031 In V_WAIT, avm_readdata SHALL be sampled exactly RD_LATENCY cycles after read acceptance and compared to entry k.
REQ-032 On the first mismatch, o_error SHALL be set and o_err_index SHALL be loaded with k; later mismatches do not change o_err_index; verification always completes all 16 entries.
REQ-033 W_CTRL and W_START SHALL execute even when o_error = 1.
REQ-034 o_error and o_err_index SHALL be cleared when i_go is accepted and SHALL hold their values through IDLE otherwise.
REQ-035 o_done SHALL pulse in the cycle the FSM returns to IDLE.
REQ-036 o_busy SHALL be 0 in the cycle o_done is 1.
REQ-037 Index and k counters SHALL wrap from 15 to 0 only at pass boundaries.
REQ-038 With waitrequest = 0, VERIFY = 0 and RD_LATENCY = 1, the transfer count SHALL be 34 and i_go-to-o_done latency SHALL be 36 cycles.

Reset
REQ-039 While reset = 0: FSM in IDLE; all avm_* outputs 0; o_busy, o_done, o_error 0; o_err_index 0; counters 0.
REQ-040 Reset asserted mid-run SHALL abort immediately with no completion pulse.
REQ-041 After reset release, the block SHALL wait in IDLE for a new i_go.

Verification
REQ-042 i_base = 0x1000, i_step = 0x10, VERIFY = 0, no stall -> writes (2,k),(3,0x1000+16k) for k = 0..15, then (0,0x3) with both enables = 1, then (1,x), with o_done at cycle 36.
REQ-043 i_base = 0xFFFFFFF0, i_step = 0x8 -> entry 2 = 0x00000000 (wrap), entry 15 = 0x00000068.
REQ-044 Random avm_waitrequest bursts of 0-5 cycles -> outputs stable while stalled, same transfer list as the no-stall run.
REQ-045 VERIFY = 1 with slave corrupting table[5] and table[9] on read -> o_error = 1, o_err_index = 5, control and start still written.
REQ-046 i_go pulsed while busy, then reset asserted mid-table -> second i_go ignored, all outputs 0 immediately, no o_done.

Source files
------------

// File: rtl/dds_avalon_cfg_master.sv
// +------------------------------------------------------------------------+
// | dds_avalon_cfg_master: programs a 16-entry DDS increment table and     |
// | control/start registers over Avalon-MM, with optional read-back check. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module dds_avalon_cfg_master #(
  parameter int VERIFY     = 1,
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_go,
  input  logic [31:0] i_base,
  input  logic [31:0] i_step,
  input  logic        i_enable,
  input  logic        i_tipo_ajuste,
  output logic        avm_chipselect,
  output logic        avm_write,
  output logic        avm_read,
  output logic [2:0]  avm_address,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [3:0]  o_err_index
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_W_IDX   = 4'd1;
  localparam logic [3:0] S_W_DAT   = 4'd2;
  localparam logic [3:0] S_V_IDX   = 4'd3;
  localparam logic [3:0] S_V_RD    = 4'd4;
  localparam logic [3:0] S_V_WAIT  = 4'd5;
  localparam logic [3:0] S_W_CTRL  = 4'd6;
  localparam logic [3:0] S_W_START = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  localparam logic [1:0] LAT_LAST  = 2'(RD_LATENCY - 1);

  logic [3:0]  state_q, state_d;
  logic [3:0]  k_q, k_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] base_q, base_d;
  logic [31:0] step_q, step_d;
  logic        en_q, en_d;
  logic        tipo_q, tipo_d;
  logic [1:0]  lat_q, lat_d;
  logic        error_q, error_d;
  logic [3:0]  err_index_q, err_index_d;
  logic        done_q, done_d;
  logic        w_xfer_ok;

  assign w_xfer_ok = !avm_waitrequest;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= 4'd0;
      acc_q       <= 32'd0;
      base_q      <= 32'd0;
      step_q      <= 32'd0;
      en_q        <= 1'b0;
      tipo_q      <= 1'b0;
      lat_q       <= 2'd0;
      error_q     <= 1'b0;
      err_index_q <= 4'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      base_q      <= base_d;
      step_q      <= step_d;
      en_q        <= en_d;
      tipo_q      <= tipo_d;
      lat_q       <= lat_d;
      error_q     <= error_d;
      err_index_q <= err_index_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    base_d      = base_q;
    step_d      = step_q;
    en_d        = en_q;
    tipo_d      = tipo_q;
    lat_d       = lat_q;
    error_d     = error_q;
    err_index_d = err_index_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_go) begin
          base_d      = i_base;
          step_d      = i_step;
          en_d        = i_enable;
          tipo_d      = i_tipo_ajuste;
          acc_d       = i_base;
          k_d         = 4'd0;
          error_d     = 1'b0;
          err_index_d = 4'd0;
          state_d     = S_W_IDX;
        end
      end
      S_W_IDX: if (w_xfer_ok) state_d = S_W_DAT;
      S_W_DAT: begin
        if (w_xfer_ok) begin
          acc_d = acc_q + step_q;
          k_d   = k_q + 4'd1;
          if (k_q != 4'd15) begin
            state_d = S_W_IDX;
          end else if (VERIFY != 0) begin
            // Restart the accumulator so the check pass regenerates each entry.
            acc_d   = base_q;
            state_d = S_V_IDX;
          end else begin
            state_d = S_W_CTRL;
          end
        end
      end
      S_V_IDX: if (w_xfer_ok) state_d = S_V_RD;
      S_V_RD: begin
        if (w_xfer_ok) begin
          lat_d   = 2'd0;
          state_d = S_V_WAIT;
        end
      end
      S_V_WAIT: begin
        if (lat_q == LAT_LAST) begin
          if ((avm_readdata != acc_q) && !error_q) begin
            error_d     = 1'b1;
            err_index_d = k_q;
          end
          acc_d   = acc_q + step_q;
          k_d     = k_q + 4'd1;
          state_d = (k_q == 4'd15) ? S_W_CTRL : S_V_IDX;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_W_CTRL:  if (w_xfer_ok) state_d = S_W_START;
      S_W_START: if (w_xfer_ok) state_d = S_DONE;
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    avm_chipselect = 1'b0;
    avm_write      = 1'b0;
    avm_read       = 1'b0;
    avm_address    = 3'd0;
    avm_writedata  = 32'd0;
    case (state_q)
      S_W_IDX, S_V_IDX: begin
        avm_chipselect = 1'b1;
        avm_write      = 1'b1;
        avm_address    = 3'd2;
        avm_writedata  = {28'd0, k_q};
      end
      S_W_DAT: begin
        avm_chipselect = 1'b1;
        avm_write      = 1'b1;
        avm_address    = 3'd3;
        avm_writedata  = acc_q;
      end
      S_V_RD: begin
        avm_chipselect = 1'b1;
        avm_read       = 1'b1;
        avm_address    = 3'd3;
      end
      S_W_CTRL: begin
        avm_chipselect = 1'b1;
        avm_write      = 1'b1;
        avm_address    = 3'd0;
        avm_writedata  = {30'd0, tipo_q, en_q};
      end
      S_W_START: begin
        avm_chipselect = 1'b1;
        avm_write      = 1'b1;
        avm_address    = 3'd1;
        avm_writedata  = 32'd1;
      end
      default: ;
    endcase
    o_busy      = (state_q != S_IDLE);
    o_done      = done_q;
    o_error     = error_q;
    o_err_index = err_index_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_dds_avalon_cfg_master.sv
// +------------------------------------------------------------------------+
// | tb_dds_avalon_cfg_master: directed bench, one no-verify and one verify |
// | instance, each served by a small Avalon slave model. Revision: 1.0     |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_dds_avalon_cfg_master;

  localparam int LAT1 = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] base = 32'd0, step = 32'd0;
  logic        en = 1'b0, tipo = 1'b0;
  int          cyc = 0;
  int          total = 0, bad = 0;

  // instance 0: VERIFY = 0, RD_LATENCY = 1
  logic        go0 = 1'b0, wr0 = 1'b0;
  logic        cs0, we0, re0, busy0, done0, err0;
  logic [2:0]  addr0;
  logic [31:0] wd0, rdat0 = 32'd0;
  logic [3:0]  eidx0;
  // instance 1: VERIFY = 1, RD_LATENCY = 2
  logic        go1 = 1'b0;
  logic        wr1 = 1'b0;
  logic        cs1, we1, re1, busy1, done1, err1;
  logic [2:0]  addr1;
  logic [31:0] wd1, rdat1 = 32'd0;
  logic [3:0]  eidx1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dds_avalon_cfg_master #(.VERIFY(0), .RD_LATENCY(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_go(go0), .i_base(base), .i_step(step),
    .i_enable(en), .i_tipo_ajuste(tipo), .avm_chipselect(cs0), .avm_write(we0),
    .avm_read(re0), .avm_address(addr0), .avm_writedata(wd0), .avm_readdata(rdat0),
    .avm_waitrequest(wr0), .o_busy(busy0), .o_done(done0), .o_error(err0),
    .o_err_index(eidx0));

  dds_avalon_cfg_master #(.VERIFY(1), .RD_LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_go(go1), .i_base(base), .i_step(step),
    .i_enable(en), .i_tipo_ajuste(tipo), .avm_chipselect(cs1), .avm_write(we1),
    .avm_read(re1), .avm_address(addr1), .avm_writedata(wd1), .avm_readdata(rdat1),
    .avm_waitrequest(wr1), .o_busy(busy1), .o_done(done1), .o_error(err1),
    .o_err_index(eidx1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Slave 0: logs every accepted write, keeps a table image.
  logic [34:0] log0[$];
  logic [31:0] tbl0[16];
  logic [3:0]  idx0 = 4'd0;
  always @(posedge clk) begin
    if (rst_n && cs0 && !wr0 && we0) begin
      log0.push_back({addr0, wd0});
      if (addr0 == 3'd2) idx0 = wd0[3:0];
      if (addr0 == 3'd3) tbl0[idx0] = wd0;
    end
  end

  // Slave 1: table with optional read corruption of entries 5 and 9.
  logic [31:0] tbl1[16];
  logic [3:0]  idx1 = 4'd0;
  logic        corrupt = 1'b0;
  int          ctrl_wr = 0, start_wr = 0;
  logic [31:0] ctrl_val = 32'd0;
  logic [31:0] pipe1[4];
  always @(posedge clk) begin
    logic [31:0] nd;
    nd = 32'hDEAD_BEEF;
    if (rst_n && cs1 && !wr1) begin
      if (we1) begin
        if (addr1 == 3'd2) idx1 = wd1[3:0];
        if (addr1 == 3'd3) tbl1[idx1] = wd1;
        if (addr1 == 3'd0) begin ctrl_wr++; ctrl_val = wd1; end
        if (addr1 == 3'd1) start_wr++;
      end else if (re1) begin
        nd = tbl1[idx1] ^ ((corrupt && (idx1 == 4'd5 || idx1 == 4'd9)) ? 32'h1 : 32'h0);
      end
    end
    #1;
    for (int i = 3; i > 0; i--) pipe1[i] = pipe1[i-1];
    pipe1[0] = nd;
    rdat1 = pipe1[LAT1-1];
  end

  // Random stall generator for instance 0 plus stability monitor.
  logic stall_en = 1'b0;
  int   burst = 0, stab_bad = 0;
  logic prev_stall = 1'b0;
  logic [37:0] snap = '0;
  always @(posedge clk) begin
    #1;
    if (stall_en) begin
      if (burst > 0) begin wr0 = 1'b1; burst--; end
      else begin wr0 = 1'b0; burst = $urandom_range(0, 5); end
    end else begin
      wr0 = 1'b0;
    end
  end
  always @(negedge clk) begin
    if (prev_stall && (snap !== {cs0, we0, re0, addr0, wd0})) stab_bad++;
    prev_stall = cs0 && wr0;
    snap = {cs0, we0, re0, addr0, wd0};
  end

  task automatic run0(input logic [31:0] b, input logic [31:0] s, input logic e,
                      input logic t, input bit stall, input bit disturb, input string nm);
    int c0, lat;
    logic [34:0] ex;
    bit got;
    log0.delete();
    stall_en = stall;
    stab_bad = 0;
    @(negedge clk);
    base = b; step = s; en = e; tipo = t; go0 = 1'b1; c0 = cyc;
    @(negedge clk);
    go0 = 1'b0;
    if (disturb) begin
      base = 32'h0BAD_0BAD; step = 32'h7; en = ~e; tipo = ~t;
    end
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      if (disturb && i == 5) go0 = 1'b1;
      if (disturb && i == 6) go0 = 1'b0;
      if (done0) got = 1'b1;
      else @(negedge clk);
    end
    chk({nm, " done_seen"}, 32'(got), 32'd1);
    lat = cyc - c0;
    if (!stall) chk({nm, " latency"}, lat, 32'd36);
    chk({nm, " busy_at_done"}, 32'(busy0), 32'd0);
    chk({nm, " xfer_count"}, log0.size(), 32'd34);
    for (int i = 0; i < 34 && i < log0.size(); i++) begin
      if (i < 32) ex = (i % 2 == 0) ? {3'd2, 32'(i / 2)} : {3'd3, b + 32'(i / 2) * s};
      else if (i == 32) ex = {3'd0, 30'd0, t, e};
      else ex = {3'd1, log0[i][31:0]};
      chk($sformatf("%s xfer%0d", nm, i), {29'd0, log0[i][34:32]}, {29'd0, ex[34:32]});
      if (i < 33) chk($sformatf("%s data%0d", nm, i), log0[i][31:0], ex[31:0]);
    end
    if (stall) chk({nm, " stable_while_stalled"}, stab_bad, 32'd0);
    stall_en = 1'b0;
  endtask

  task automatic run1(input bit corr, input logic [31:0] b, input logic [31:0] s,
                      input logic [31:0] exp_err, input logic [31:0] exp_idx, input string nm);
    bit got;
    corrupt = corr; ctrl_wr = 0; start_wr = 0;
    @(negedge clk);
    base = b; step = s; en = 1'b1; tipo = 1'b0; go1 = 1'b1;
    @(negedge clk);
    go1 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      if (done1) got = 1'b1;
      else @(negedge clk);
    end
    chk({nm, " done_seen"}, 32'(got), 32'd1);
    chk({nm, " error"}, 32'(err1), exp_err);
    chk({nm, " err_index"}, 32'(eidx1), exp_idx);
    chk({nm, " ctrl_written"}, ctrl_wr, 32'd1);
    chk({nm, " ctrl_value"}, ctrl_val, 32'd1);
    chk({nm, " start_written"}, start_wr, 32'd1);
    repeat (3) @(negedge clk);
    chk({nm, " error_held"}, 32'(err1), exp_err);
    chk({nm, " err_index_held"}, 32'(eidx1), exp_idx);
  endtask

  initial begin
    int dn;
    repeat (3) @(negedge clk);
    chk("rst cs", 32'(cs0), 0);
    chk("rst strobes", {30'd0, we0, re0}, 0);
    chk("rst busy_done_err", {29'd0, busy0, done0, err0}, 0);
    chk("rst err_index", 32'(eidx0), 0);
    chk("rst addr_wdata", {29'd0, addr0} | wd0, 0);
    rst_n = 1'b1;

    run0(32'h0000_1000, 32'h10, 1'b1, 1'b1, 1'b0, 1'b1, "runA");
    run0(32'hFFFF_FFF0, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0, "runB");
    chk("wrap entry2", tbl0[2], 32'h0000_0000);
    chk("wrap entry15", tbl0[15], 32'h0000_0068);

    run1(1'b1, 32'h0000_0100, 32'h3, 1, 5, "verify_bad");
    run1(1'b0, 32'h1234_0000, 32'h11, 0, 0, "verify_ok");

    // Abort mid-table with an asynchronous reset.
    @(negedge clk);
    base = 32'h0000_2000; step = 32'h4; go0 = 1'b1;
    @(negedge clk);
    go0 = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrun busy", 32'(busy0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort strobes", {29'd0, cs0, we0, re0}, 0);
    chk("abort busy_done", {30'd0, busy0, done0}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done0 || busy0 || cs0) dn++;
    end
    chk("idle after abort", dn, 0);

    run0(32'h0000_1000, 32'h10, 1'b1, 1'b1, 1'b1, 1'b0, "runStall");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
